// File: rtl/wr_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the arbiter state encoding, parameter defaults and burst-counter helpers.
package wr_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int DSIZE_DEF = 8;
    localparam int BURST_DEF = 4;
    localparam int CNT_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // True when one more write brings the counter to the burst limit.
    // Computed one bit wider so that a burst of 16 does not wrap.
    function automatic logic burst_done(input logic [CNT_W-1:0] cnt, input int burst);
        return (({1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1}) == (CNT_W+1)'(burst));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester selector.
// Searches for a valid requester starting at last_id+1 and wrapping modulo NREQ.
module rr_pick
    import wr_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ_DEF)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last_id,
    output logic            any,
    output logic [IDW-1:0]  next_id
);

    int idx_s;

    // Walk from the farthest to the nearest candidate so the nearest valid one wins.
    always_comb begin
        any     = 1'b0;
        next_id = '0;
        idx_s   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx_s = (int'(last_id) + k) % NREQ;
            if (valid[idx_s]) begin
                any     = 1'b1;
                next_id = IDW'(idx_s);
            end else begin
                any     = any;
            end
        end
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Arbitrates NREQ write requesters onto a single FIFO write port.
// Grants last up to BURST words; one idle cycle separates consecutive grants.
module wr_port_arbiter
    import wr_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DSIZE = DSIZE_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic                     wclk,
    input  logic                     w_rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DSIZE-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DSIZE-1:0]         wdata,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    logic [IDW-1:0]   grant_id_r;
    logic [IDW-1:0]   grant_nxt_s;
    logic [IDW-1:0]   last_id_r;
    logic [IDW-1:0]   last_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             any_s;
    logic [IDW-1:0]   pick_s;
    logic             owner_valid_s;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .valid   (req_valid),
        .last_id (last_id_r),
        .any     (any_s),
        .next_id (pick_s)
    );

    // Write-side handshake; kept combinational so wfull gates winc in the same cycle.
    always_comb begin
        req_ready     = '0;
        owner_valid_s = req_valid[grant_id_r];
        if (state_r == GRANT) begin
            req_ready[grant_id_r] = ~wfull;
        end else begin
            req_ready = '0;
        end
        winc  = owner_valid_s & req_ready[grant_id_r];
        wdata = req_data[int'(grant_id_r)*DSIZE +: DSIZE];
        busy  = (state_r == GRANT);
    end

    assign grant_id = grant_id_r;

    // Next-state logic: grant on any pending request, release on burst end or valid drop.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_id_r;
        last_nxt_s  = last_id_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (any_s && !wfull) begin
                    state_nxt_s = GRANT;
                    grant_nxt_s = pick_s;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (winc) begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if ((winc && burst_done(cnt_r, BURST)) || !owner_valid_s) begin
                    state_nxt_s = IDLE;
                    last_nxt_s  = grant_id_r;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and arbitration registers; last_id resets so requester 0 is searched first.
    always_ff @(posedge wclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_r    <= IDLE;
            grant_id_r <= '0;
            last_id_r  <= IDW'(NREQ - 1);
            cnt_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            grant_id_r <= grant_nxt_s;
            last_id_r  <= last_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

endmodule

// File: doc/wr_port_arbiter.md
WR_PORT_ARBITER -- requirements
Module: wr_port_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters sharing one FIFO write port (2..8) SHALL be supported.
REQ-002 Parameter DSIZE, default 8, data word width SHALL be supported.
REQ-003 Parameter BURST, default 4, maximum writes per grant (1..16) SHALL be supported.
REQ-004 Ports SHALL be, in order:
- wclk  in  1  write-domain clock.
- w_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester word-available.
- req_data  in  NREQ*DSIZE  packed words, requester i at bits [i*DSIZE +: DSIZE].
- req_ready  out  NREQ  per-requester word-accepted-this-cycle qualifier.
- wfull  in  1  FIFO full flag from the write-pointer logic.
- winc  out  1  FIFO write enable.
- wdata  out  DSIZE  FIFO write data.
- grant_id  out  $clog2(NREQ)  index of the current owner.
- busy  out  1  a grant is active.

Function
REQ-005 The FSM SHALL have two states, IDLE and GRANT, both registered.
REQ-006 IDLE: if any req_valid=1 and wfull=0, the arbiter SHALL register grant_id = first requester with valid=1, searching round-robin from last_id+1 modulo NREQ, and SHALL enter GRANT on the next edge; otherwise it SHALL stay in IDLE.
REQ-007 GRANT: req_ready[grant_id] SHALL equal !wfull (combinational); all other req_ready bits SHALL be 0; in IDLE all req_ready bits SHALL be 0.
REQ-008 winc SHALL equal req_valid[grant_id] & req_ready[grant_id] with zero latency, and wdata SHALL equal req_data slice grant_id; wdata is a don't-care when winc=0.
REQ-009 A 4-bit burst counter SHALL increment on each winc and SHALL clear on entry to GRANT.
REQ-010 GRANT->IDLE SHALL occur on the edge where either the winc raises the count to BURST or req_valid[grant_id]=0; last_id SHALL then be set to grant_id.
REQ-011 wfull=1 in GRANT SHALL stall: no winc, counter held, grant held, no timeout.
REQ-012 A requester dropping valid while wfull=1 SHALL release the grant per REQ-010.
REQ-013 One idle cycle (IDLE) SHALL separate consecutive grants; peak throughput is BURST words per BURST+1 cycles.
REQ-014 A requester with valid continuously high SHALL be granted within NREQ-1 other grants (starvation bound).
REQ-015 busy SHALL be 1 exactly in GRANT.
REQ-016 winc SHALL never assert while wfull=1, and never for more than one requester per cycle.

Reset
REQ-017 While w_rst_n=0: state=IDLE, counter=0, grant_id=0, last_id=NREQ-1 (requester 0 has first priority), busy=0, req_ready=0, winc=0.
REQ-018 Reset assertion mid-burst SHALL abort immediately with no further winc; words not yet accepted remain the requester's responsibility.
REQ-019 Reset deassertion SHALL be synchronized externally; the first arbitration decision SHALL occur on the first wclk edge after release.

Structure
REQ-020 Package wr_arb_pkg SHALL hold the state enum (IDLE, GRANT), the default NREQ/DSIZE/BURST constants, and the counter width constant.
REQ-021 Combinational sub-module rr_pick SHALL take (valid vector, last_id) and return (any, next_id); it SHALL be instantiated once.
REQ-022 wr_port_arbiter SHALL connect winc/wdata directly to the FIFO write side, with no registering between winc and wfull.

Verification
REQ-023 Reset, then req_valid=0001, wfull=0 held: grant_id=0; 4 winc pulses with req_data[0] words 0x11..0x14; return to IDLE; regrant of 0 after one cycle.
REQ-024 req_valid=1111 all held, BURST=4: grant order SHALL be 0,1,2,3,0; each grant yields exactly 4 winc; one idle cycle between grants.
REQ-025 Grant to 2, wfull=1 after the 2nd write for 5 cycles: winc=0 and req_ready=0 for those 5 cycles; grant held; the remaining 2 writes complete after wfull=0.
REQ-026 Grant to 1, req_valid[1] dropped after 1 write: IDLE next cycle, last_id=1; a pending requester 3 SHALL be granted next before requester 0.
REQ-027 w_rst_n pulsed low for one cycle mid-burst (count=2): winc, busy, and req_ready SHALL go 0 asynchronously; after release with req_valid=1010, requester 1 SHALL be granted first.
REQ-028 Assertions SHALL hold throughout: winc implies !wfull; req_ready is one-hot or zero; no requester starves beyond NREQ-1 grants.
